// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU debug register-dump path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: dump FSM state enum, register count/width constants, default
// end-of-test sentinel and timeout, and the regs_flat slicing helper
// (reg i lives at bits [32*i+31 : 32*i]).
package cpu_dbg_pkg;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam int WORD_W   = 32;
  localparam int FLAT_W   = NUM_REGS * WORD_W;
  localparam int CNT_W    = 16;

  localparam int          DEF_SENTINEL_REG   = 11;
  localparam logic [31:0] DEF_SENTINEL_VAL   = 32'h0000c0de;
  localparam int          DEF_TIMEOUT_CYCLES = 50;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [FLAT_W-1:0] flat_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

  // Extract register word `idx` from the flattened register-file tap.
  function automatic word_t reg_word(input flat_t flat, input int idx);
    return flat[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dump_snapshot_buf.sv
// Snapshot buffer: 32x32 register array loaded in parallel from regs_flat.
// Latency: load takes effect at the edge it is sampled; read port is combinational.
// Backpressure: none; contents only change on load or reset.
//
// Ports:
//   clk, reset    - clock and synchronous active-low reset
//   load          - capture every register word from regs_flat this edge
//   regs_flat     - flattened register-file tap (32 words)
//   rd_idx        - read index
//   rd_data       - snapshot word at rd_idx
module dump_snapshot_buf
  import cpu_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [FLAT_W-1:0] regs_flat,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  word_t mem_q [NUM_REGS];
  word_t mem_d [NUM_REGS];

  // x0 is hardwired zero in the core, so the tap value for it is never trusted.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
      if (load) begin
        mem_d[i] = (i == 0) ? '0 : reg_word(regs_flat, i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/regfile_dump_tx.sv
// Register-file dump transmitter: waits for end-of-test sentinel or timeout, snapshots x0..x31, streams them.
// Latency: capture at the matching edge, first word valid right after it; one word per handshake.
// Backpressure: valid/ready; word held stable while tx_valid && !tx_ready, stalls of any length allowed.
//
// Ports:
//   clk, reset   - clock and synchronous active-low reset
//   start        - one-cycle arm pulse, accepted only in IDLE or DONE
//   regs_flat    - register-file tap, reg i at bits [32*i+31 : 32*i]
//   tx_ready     - consumer ready
//   tx_valid     - snapshot word available
//   tx_data      - snapshot word
//   tx_index     - register index of tx_data
//   tx_last      - marks index 31 while tx_valid
//   busy         - waiting for capture or sending
//   done         - whole snapshot sent; held until the next accepted start
//   timed_out    - capture was forced by the cycle timeout
module regfile_dump_tx
  import cpu_dbg_pkg::*;
#(
  parameter int          SENTINEL_REG   = DEF_SENTINEL_REG,
  parameter logic [31:0] SENTINEL_VAL   = DEF_SENTINEL_VAL,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [FLAT_W-1:0] regs_flat,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [WORD_W-1:0] tx_data,
  output logic [IDX_W-1:0]  tx_index,
  output logic              tx_last,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  localparam cnt_t TIMEOUT_LIM = cnt_t'(TIMEOUT_CYCLES);
  localparam idx_t LAST_IDX    = idx_t'(NUM_REGS - 1);

  dump_state_e state_q, state_d;
  idx_t        idx_q, idx_d;
  cnt_t        cnt_q, cnt_d;
  logic        timed_out_q, timed_out_d;

  logic  snap_load;
  logic  sentinel_hit;
  cnt_t  cnt_inc;
  word_t rd_data;

  dump_snapshot_buf u_snap (
    .clk       (clk),
    .reset     (reset),
    .load      (snap_load),
    .regs_flat (regs_flat),
    .rd_idx    (idx_q),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    timed_out_d  = timed_out_q;
    snap_load    = 1'b0;
    sentinel_hit = (reg_word(regs_flat, SENTINEL_REG) == SENTINEL_VAL);
    cnt_inc      = cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_WAIT;
          idx_d       = '0;
          cnt_d       = '0;
          timed_out_d = 1'b0;
        end
      end

      ST_WAIT: begin
        // Sentinel is tested before the timeout, so a hit on the same edge
        // that would also expire the counter reports a clean capture.
        if (sentinel_hit) begin
          snap_load   = 1'b1;
          state_d     = ST_SEND;
          idx_d       = '0;
          timed_out_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT_LIM) begin
            snap_load   = 1'b1;
            state_d     = ST_SEND;
            idx_d       = '0;
            timed_out_d = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (tx_ready) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All outputs decode directly from flops, so they only move at clock edges
  // and stay stable through a stall.
  assign tx_valid  = (state_q == ST_SEND);
  assign tx_data   = tx_valid ? rd_data : '0;
  assign tx_index  = idx_q;
  assign tx_last   = tx_valid && (idx_q == LAST_IDX);
  assign busy      = (state_q == ST_WAIT) || (state_q == ST_SEND);
  assign done      = (state_q == ST_DONE);
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
module tb_regfile_dump_tx;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1023:0] regs_flat;
  logic          tx_ready;
  logic          tx_valid;
  logic [31:0]   tx_data;
  logic [4:0]    tx_index;
  logic          tx_last;
  logic          busy;
  logic          done;
  logic          timed_out;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  i;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   hs_count = 0;

  logic        stall_q = 1'b0;
  logic [31:0] stall_data;
  logic [4:0]  stall_idx;

  regfile_dump_tx dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .regs_flat (regs_flat),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_index  (tx_index),
    .tx_last   (tx_last),
    .busy      (busy),
    .done      (done),
    .timed_out (timed_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, a valid&&ready here is the
  // handshake the next rising edge will take.
  always @(negedge clk) begin
    exp_t e;
    if (stall_q) begin
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", tx_data, stall_data);
      check("stall_index", 32'(tx_index), 32'(stall_idx));
    end
    if (reset && tx_valid && tx_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(tx_index), 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("word_data", tx_data, e.d);
        check("word_index", 32'(tx_index), 32'(e.i));
        check("word_last", 32'(tx_last), 32'(e.l));
      end
    end
    stall_q    = reset && tx_valid && !tx_ready;
    stall_data = tx_data;
    stall_idx  = tx_index;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat_word(input int i, input logic [31:0] x11v);
    if (i == 0) return 32'h0;
    if (i == 11) return x11v;
    return 32'(i) * 32'h11111111;
  endfunction

  // x0 is deliberately nonzero on the tap; the snapshot must still read 0.
  task automatic set_regs(input logic [31:0] x11v);
    for (int i = 0; i < 32; i++) begin
      regs_flat[i*32 +: 32] = (i == 0) ? 32'hDEADBEEF : pat_word(i, x11v);
    end
  endtask

  task automatic push_expected(input logic [31:0] x11v);
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.d = pat_word(i, x11v);
      e.i = 5'(i);
      e.l = (i == 31);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (!tx_valid && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!tx_valid) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_stream(input bit bp, input int start_at, input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      tx_ready = bp ? ((cycles % 4 == 0) || (cycles % 4 == 3)) : 1'b1;
      start    = (cycles == start_at);
      tick();
      cycles++;
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    if (!done) check("stream_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_end(input string tag, input logic exp_to);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid_after"}, 32'(tx_valid), 32'd0);
    check({tag, "_timed_out"}, 32'(timed_out), 32'(exp_to));
    check({tag, "_handshakes"}, 32'(hs_count), 32'd32);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int k;

    reset    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b1;
    set_regs(32'h0);
    tick();
    tick();
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", tx_data, 32'd0);
    check("rst_index", 32'(tx_index), 32'd0);
    check("rst_last", 32'(tx_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timed_out", 32'(timed_out), 32'd0);
    reset = 1'b1;
    tick();

    // Sentinel hit 5 cycles after start, ready held high.
    set_regs(32'h0);
    hs_count = 0;
    push_expected(32'h0000c0de);
    do_start();
    check("s1_busy_at_start", 32'(busy), 32'd1);
    check("s1_idle_valid", 32'(tx_valid), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("s1_still_waiting", 32'(tx_valid), 32'd0);
    regs_flat[11*32 +: 32] = 32'h0000c0de;
    wait_valid(10, cyc);
    check("s1_capture_latency", 32'(cyc), 32'd1);
    check("s1_first_data", tx_data, 32'h0);
    check("s1_timed_out_send", 32'(timed_out), 32'd0);
    drive_stream(1'b0, -1, 100, cyc);
    check("s1_stream_cycles", 32'(cyc), 32'd32);
    check_end("s1", 1'b0);

    // Timeout: x11 never matches.
    set_regs(32'h0000c0df);
    hs_count = 0;
    push_expected(32'h0000c0df);
    do_start();
    check("s2_done_cleared", 32'(done), 32'd0);
    wait_valid(100, cyc);
    check("s2_timeout_latency", 32'(cyc), 32'd50);
    check("s2_timed_out_send", 32'(timed_out), 32'd1);
    drive_stream(1'b0, -1, 100, cyc);
    check("s2_stream_cycles", 32'(cyc), 32'd32);
    check_end("s2", 1'b1);

    // Backpressure 1,0,0,1 and regs overwritten right after capture.
    set_regs(32'h0000c0de);
    hs_count = 0;
    push_expected(32'h0000c0de);
    do_start();
    check("s3_timed_out_cleared", 32'(timed_out), 32'd0);
    wait_valid(10, cyc);
    check("s3_capture_latency", 32'(cyc), 32'd1);
    regs_flat = {1024{1'b1}};
    drive_stream(1'b1, -1, 200, cyc);
    check("s3_stream_cycles", 32'(cyc), 32'd64);
    check_end("s3", 1'b0);

    // Reset mid-SEND at index 10, then a fresh full stream.
    set_regs(32'h0000c0de);
    hs_count = 0;
    push_expected(32'h0000c0de);
    do_start();
    wait_valid(10, cyc);
    k = 0;
    while (!(tx_valid && tx_index == 5'd10) && k < 100) begin
      tick();
      k++;
    end
    check("s4_reached_idx10", 32'(tx_index), 32'd10);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("s4_valid", 32'(tx_valid), 32'd0);
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_done", 32'(done), 32'd0);
    check("s4_index", 32'(tx_index), 32'd0);
    check("s4_data", tx_data, 32'd0);
    check("s4_handshakes", 32'(hs_count), 32'd10);
    check("s4_remaining", 32'(exp_q.size()), 32'd22);
    exp_q.delete();
    tick();
    check("s4_idle_valid", 32'(tx_valid), 32'd0);
    hs_count = 0;
    push_expected(32'h0000c0de);
    do_start();
    wait_valid(10, cyc);
    check("s4_restart_latency", 32'(cyc), 32'd1);
    drive_stream(1'b0, -1, 100, cyc);
    check("s4_stream_cycles", 32'(cyc), 32'd32);
    check_end("s4", 1'b0);

    // Match and timeout on the same edge; start pulsed during SEND.
    set_regs(32'h0);
    hs_count = 0;
    push_expected(32'h0000c0de);
    do_start();
    for (int i = 0; i < 49; i++) tick();
    check("s5_still_waiting", 32'(tx_valid), 32'd0);
    regs_flat[11*32 +: 32] = 32'h0000c0de;
    wait_valid(10, cyc);
    check("s5_capture_latency", 32'(cyc), 32'd1);
    check("s5_timed_out_send", 32'(timed_out), 32'd0);
    drive_stream(1'b0, 5, 100, cyc);
    check("s5_stream_cycles", 32'(cyc), 32'd32);
    check_end("s5", 1'b0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
